// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions for the word aligner, TMDS decoder and sync detector.
package hdmi_pkg;

  localparam logic [9:0] TMDS_CTL0 = 10'h354;
  localparam logic [9:0] TMDS_CTL1 = 10'h0AB;
  localparam logic [9:0] TMDS_CTL2 = 10'h154;
  localparam logic [9:0] TMDS_CTL3 = 10'h2AB;

  typedef logic [1:0] tmds_ctl_code_t;

  typedef enum logic {
    SEARCH,
    LOCKED
  } align_state_t;

endpackage

// File: rtl/hdmi_bitslip.sv
// 20-to-10 barrel select over the current and previous deserializer words,
// registered once; bit 0 of the window is the earliest received bit.
module hdmi_bitslip
  import hdmi_pkg::*;
(
  input  logic       i_hclk,
  input  logic       i_reset,
  input  logic [3:0] i_offset,
  input  logic [9:0] i_word,
  output logic [9:0] o_aligned
);

  logic [9:0]  r_prev;
  logic [19:0] window;
  logic [9:0]  sel;

  // Offsets 10..15 never occur; they fall through to the zero default.
  always_comb begin
    window = {i_word, r_prev};
    sel    = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (i_offset == 4'(k)) sel = window[k +: 10];
    end
  end

  always_ff @(posedge i_hclk) begin
    if (i_reset) begin
      r_prev    <= '0;
      o_aligned <= '0;
    end else begin
      r_prev    <= i_word;
      o_aligned <= sel;
    end
  end

endmodule

// File: rtl/hdmi_word_align.sv
// Per-channel TMDS word aligner: hunts the ten bit offsets for runs of
// control tokens, locks on one, and emits aligned words with token status.
module hdmi_word_align
  import hdmi_pkg::*;
#(
  parameter int unsigned LOCK_COUNT     = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned LOSS_TIMEOUT   = 8192
) (
  input  logic       i_hclk,
  input  logic       i_reset,
  input  logic [9:0] i_word,
  output logic [9:0] o_word,
  output logic       o_ctl,
  output logic [1:0] o_ctl_code,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned TMO_W  = $clog2(SEARCH_TIMEOUT);
  localparam int unsigned LOSS_W = $clog2(LOSS_TIMEOUT);

  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_COUNT);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  align_state_t      state;
  logic [9:0]        r_aligned;
  logic              ctl_hit;
  tmds_ctl_code_t    ctl_code;
  logic [RUN_W-1:0]  run_cnt;
  logic [RUN_W-1:0]  run_next;
  logic              run_hit;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [LOSS_W-1:0] loss_cnt;
  logic [1:0]        holdoff;

  hdmi_bitslip u_bitslip (
    .i_hclk    (i_hclk),
    .i_reset   (i_reset),
    .i_offset  (o_offset),
    .i_word    (i_word),
    .o_aligned (r_aligned)
  );

  always_comb begin
    ctl_hit  = 1'b1;
    ctl_code = '0;
    case (r_aligned)
      TMDS_CTL0: ctl_code = 2'b00;
      TMDS_CTL1: ctl_code = 2'b01;
      TMDS_CTL2: ctl_code = 2'b10;
      TMDS_CTL3: ctl_code = 2'b11;
      default:   ctl_hit  = 1'b0;
    endcase
  end

  // Tokens seen during holdoff were selected with the previous offset.
  always_comb begin
    run_next = '0;
    if (holdoff == 2'd0 && o_ctl) begin
      run_next = (run_cnt == RUN_LOCK) ? run_cnt : run_cnt + 1'b1;
    end
    run_hit = (run_next == RUN_LOCK);
  end

  always_ff @(posedge i_hclk) begin
    if (i_reset) begin
      state      <= SEARCH;
      o_word     <= '0;
      o_ctl      <= 1'b0;
      o_ctl_code <= '0;
      o_locked   <= 1'b0;
      o_offset   <= '0;
      run_cnt    <= '0;
      tmo_cnt    <= '0;
      loss_cnt   <= '0;
      holdoff    <= '0;
    end else begin
      o_word     <= r_aligned;
      o_ctl      <= ctl_hit;
      o_ctl_code <= ctl_hit ? ctl_code : 2'b00;

      case (state)
        SEARCH: begin
          if (holdoff != 2'd0) holdoff <= holdoff - 2'd1;
          // Lock takes priority over a coincident search timeout.
          if (run_hit) begin
            state    <= LOCKED;
            o_locked <= 1'b1;
            run_cnt  <= run_next;
            tmo_cnt  <= '0;
            loss_cnt <= '0;
            holdoff  <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            o_offset <= (o_offset == 4'd9) ? 4'd0 : o_offset + 4'd1;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            holdoff  <= 2'd2;
          end else begin
            run_cnt <= run_next;
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        LOCKED: begin
          if (o_ctl) begin
            loss_cnt <= '0;
          end else if (loss_cnt == LOSS_LAST) begin
            state    <= SEARCH;
            o_locked <= 1'b0;
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            loss_cnt <= '0;
            holdoff  <= '0;
          end else begin
            loss_cnt <= loss_cnt + 1'b1;
          end
        end

        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_word_align.sv
// Directed bench for hdmi_word_align with short lock/search/loss timeouts.
module tb_hdmi_word_align;

  localparam logic [9:0] TOK0  = 10'h354;
  localparam logic [9:0] TOK3  = 10'h2AB;
  localparam logic [9:0] DATA  = 10'h1F0;
  // 0x354 rotated so that offset 3 recovers it.
  localparam logic [9:0] ROT3  = 10'h2A6;
  // 0x354 rotated so that offset 9 recovers it.
  localparam logic [9:0] ROT9  = 10'h1AA;

  logic       i_hclk = 1'b0;
  logic       i_reset = 1'b0;
  logic [9:0] i_word = '0;
  logic [9:0] o_word;
  logic       o_ctl;
  logic [1:0] o_ctl_code;
  logic       o_locked;
  logic [3:0] o_offset;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;

  hdmi_word_align #(
    .LOCK_COUNT     (8),
    .SEARCH_TIMEOUT (64),
    .LOSS_TIMEOUT   (128)
  ) dut (
    .i_hclk     (i_hclk),
    .i_reset    (i_reset),
    .i_word     (i_word),
    .o_word     (o_word),
    .o_ctl      (o_ctl),
    .o_ctl_code (o_ctl_code),
    .o_locked   (o_locked),
    .o_offset   (o_offset)
  );

  always #5 i_hclk = ~i_hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input logic [9:0] w);
    i_word = w;
    @(posedge i_hclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick(10'h000);
    tick(10'h000);
    i_reset = 1'b0;
    cyc = 0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_word"},   32'(o_word),     32'h0);
    check({tag, "_ctl"},    32'(o_ctl),      32'h0);
    check({tag, "_code"},   32'(o_ctl_code), 32'h0);
    check({tag, "_locked"}, 32'(o_locked),   32'h0);
    check({tag, "_offset"}, 32'(o_offset),   32'h0);
  endtask

  initial begin
    // Scenario 1: aligned token stream from reset.
    do_reset();
    check_cleared("rst");
    for (int m = 1; m <= 12; m++) begin
      tick(TOK0);
      if (m == 2)  check("s1_word_early", 32'(o_word), 32'h0);
      if (m == 3) begin
        check("s1_word", 32'(o_word), 32'(TOK0));
        check("s1_ctl",  32'(o_ctl),  32'h1);
        check("s1_code", 32'(o_ctl_code), 32'h0);
      end
      if (m == 10) check("s1_unlocked", 32'(o_locked), 32'h0);
      if (m == 11) begin
        check("s1_locked", 32'(o_locked), 32'h1);
        check("s1_offset", 32'(o_offset), 32'h0);
      end
    end

    // Scenario 2: true alignment at offset 3.
    do_reset();
    for (int m = 1; m <= 205; m++) begin
      tick(ROT3);
      if (m == 63)  check("s2_off0", 32'(o_offset), 32'h0);
      if (m == 64)  check("s2_off1", 32'(o_offset), 32'h1);
      if (m == 128) check("s2_off2", 32'(o_offset), 32'h2);
      if (m == 191) check("s2_off2_hold", 32'(o_offset), 32'h2);
      if (m == 192) check("s2_off3", 32'(o_offset), 32'h3);
      if (m == 201) check("s2_unlocked", 32'(o_locked), 32'h0);
      if (m == 202) check("s2_locked", 32'(o_locked), 32'h1);
      if (m == 205) begin
        check("s2_word",   32'(o_word),     32'(TOK0));
        check("s2_code",   32'(o_ctl_code), 32'h0);
        check("s2_offset", 32'(o_offset),   32'h3);
      end
    end

    // Scenarios 3+4: broken run, lock, then loss with one injected token.
    do_reset();
    for (int m = 1; m <= 270; m++) begin
      if (m == 8)        tick(DATA);
      else if (m <= 30)  tick(TOK0);
      else if (m == 131) tick(TOK3);
      else               tick(DATA);
      if (m == 11)  check("s3_no_lock_run1", 32'(o_locked), 32'h0);
      if (m == 18)  check("s3_no_lock_yet",  32'(o_locked), 32'h0);
      if (m == 19)  check("s3_locked",       32'(o_locked), 32'h1);
      if (m == 133) begin
        check("s4_inj_word", 32'(o_word),     32'(TOK3));
        check("s4_inj_code", 32'(o_ctl_code), 32'h3);
      end
      if (m == 161) check("s4_held_by_inj", 32'(o_locked), 32'h1);
      if (m == 261) check("s4_still_locked", 32'(o_locked), 32'h1);
      if (m == 262) begin
        check("s4_lost",   32'(o_locked), 32'h0);
        check("s4_offset", 32'(o_offset), 32'h0);
      end
    end

    // Scenario 5: no tokens, offset wraps; stale tokens during holdoff.
    do_reset();
    for (int m = 1; m <= 660; m++) begin
      if (m >= 638 && m <= 640) tick(ROT9);
      else                      tick(DATA);
      if (m == 64)  check("s5_off1", 32'(o_offset), 32'h1);
      if (m == 576) check("s5_off9", 32'(o_offset), 32'h9);
      if (m == 639) check("s5_off9_hold", 32'(o_offset), 32'h9);
      if (m == 640) begin
        check("s5_wrap",      32'(o_offset), 32'h0);
        check("s5_stale_ctl", 32'(o_ctl),    32'h1);
      end
      if (m == 641) begin
        check("s5_stale_ctl2", 32'(o_ctl),       32'h1);
        check("s5_hold_run1",  32'(dut.run_cnt), 32'h0);
      end
      if (m == 642) check("s5_hold_run2", 32'(dut.run_cnt), 32'h0);
      if (m == 660) check("s5_no_lock", 32'(o_locked), 32'h0);
    end

    // Scenario 6: reset mid-SEARCH at offset 5, then mid-LOCKED.
    do_reset();
    for (int m = 1; m <= 330; m++) tick(DATA);
    check("s6_off5", 32'(o_offset), 32'h5);
    i_reset = 1'b1;
    tick(DATA);
    i_reset = 1'b0;
    check_cleared("s6_srch");
    cyc = 0;
    for (int m = 1; m <= 20; m++) begin
      tick(TOK0);
      if (m == 10) check("s6_relock_a0", 32'(o_locked), 32'h0);
      if (m == 11) check("s6_relock_a1", 32'(o_locked), 32'h1);
    end
    i_reset = 1'b1;
    tick(TOK0);
    i_reset = 1'b0;
    check_cleared("s6_lock");
    cyc = 0;
    for (int m = 1; m <= 12; m++) begin
      tick(TOK0);
      if (m == 10) check("s6_relock_b0", 32'(o_locked), 32'h0);
      if (m == 11) check("s6_relock_b1", 32'(o_locked), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
